// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Multi-cycle subtractor: D = A - B - borrow_in, computed SLICE bits per clock
// as the two's-complement sum A + ~B + ~borrow_in. The ripple chain is only
// SLICE bits long. The carry between slices lives in a register.
//
// Parameters:
//   WIDTH - operand/result width (must be a multiple of SLICE)
//   SLICE - bits processed per clock; N = WIDTH/SLICE slices per operation
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request pulse, accepted only when not busy
//   A, B       in   minuend / subtrahend, latched on acceptance
//   borrow_in  in   incoming borrow, latched on acceptance
//   D          out  registered difference, valid from the done cycle on
//   borrow_out out  final borrow (unsigned A < B + borrow_in)
//   busy       out  high while slices are being processed
//   done       out  one-cycle pulse when D/borrow_out are valid
//
// Optional feature (macro SUB_FLAGS_EN):
//   zero       out  registered D == 0 flag
//   overflow   out  registered signed-overflow flag
// Both flags update on the final-slice edge.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] D,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
`ifdef SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             overflow
`endif
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   nb_r;        // subtrahend stored already inverted
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   d_r;
    logic               borrow_out_r;
    logic               busy_r;
    logic               done_r;

    logic [SLICE-1:0]   a_slice_s;
    logic [SLICE-1:0]   nb_slice_s;
    logic [SLICE:0]     sum_s;
    logic [WIDTH-1:0]   d_next_s;
    logic               last_slice_s;

`ifdef SUB_FLAGS_EN
    logic               zero_r;
    logic               overflow_r;
    logic               zero_next_s;
    logic               overflow_next_s;
`endif

    // Slice adder: current slice of A + ~B + carry, merged into the D image.
    always_comb begin
        a_slice_s    = a_r[idx_r*SLICE +: SLICE];
        nb_slice_s   = nb_r[idx_r*SLICE +: SLICE];
        sum_s        = {1'b0, a_slice_s} + {1'b0, nb_slice_s}
                     + {{SLICE{1'b0}}, carry_r};
        d_next_s     = d_r;
        d_next_s[idx_r*SLICE +: SLICE] = sum_s[SLICE-1:0];
        last_slice_s = (idx_r == IDX_W'(N - 1));
    end

`ifdef SUB_FLAGS_EN
    // Flag values computed from the fully assembled result of the final slice.
    always_comb begin
        zero_next_s     = (d_next_s == {WIDTH{1'b0}});
        // Operands of differing sign and a result whose sign differs from A.
        if (a_r[WIDTH-1] != ~nb_r[WIDTH-1]) begin
            overflow_next_s = (d_next_s[WIDTH-1] != a_r[WIDTH-1]);
        end else begin
            overflow_next_s = 1'b0;
        end
    end
`endif

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            a_r          <= {WIDTH{1'b0}};
            nb_r         <= {WIDTH{1'b0}};
            carry_r      <= 1'b1;
            idx_r        <= {IDX_W{1'b0}};
            d_r          <= {WIDTH{1'b0}};
            borrow_out_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
`ifdef SUB_FLAGS_EN
            zero_r       <= 1'b0;
            overflow_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                // DONE accepts a new start exactly like IDLE (back-to-back).
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= A;
                        nb_r    <= ~B;
                        carry_r <= ~borrow_in;
                        idx_r   <= {IDX_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    d_r     <= d_next_s;
                    carry_r <= sum_s[SLICE];
                    if (last_slice_s) begin
                        // Final carry is the inverse of the borrow.
                        borrow_out_r <= ~sum_s[SLICE];
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        idx_r        <= {IDX_W{1'b0}};
                        state_r      <= ST_DONE;
`ifdef SUB_FLAGS_EN
                        zero_r       <= zero_next_s;
                        overflow_r   <= overflow_next_s;
`endif
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign D          = d_r;
    assign borrow_out = borrow_out_r;
    assign busy       = busy_r;
    assign done       = done_r;
`ifdef SUB_FLAGS_EN
    assign zero       = zero_r;
    assign overflow   = overflow_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed, self-checking bench for serial_subtractor (WIDTH=32, SLICE=4).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        borrow_in;
    logic [31:0] D;
    logic        borrow_out;
    logic        busy;
    logic        done;
`ifdef SUB_FLAGS_EN
    logic        zero;
    logic        overflow;
`endif

    int checks;
    int errors;

    serial_subtractor #(.WIDTH(32), .SLICE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A          (A),
        .B          (B),
        .borrow_in  (borrow_in),
        .D          (D),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
`ifdef SUB_FLAGS_EN
        ,
        .zero       (zero),
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done; reports falling edges elapsed and busy count.
    task automatic wait_done(output logic seen, output int lat, output int busy_cnt);
        seen     = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
    endtask

    // Counts done pulses over n falling edges.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    // Issues one operation (called at a falling edge), scrambles the inputs
    // after acceptance, and checks latency, busy length and result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic bin, input logic [31:0] exp_d, input logic exp_bo);
        logic seen;
        int   lat;
        int   bc;
        A = a; B = b; borrow_in = bin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; A = ~a; B = ~b; borrow_in = ~bin;
        wait_done(seen, lat, bc);
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        check({tag, "_D"}, D, exp_d);
        check({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, exp_bo});
    endtask

    logic seen_l;
    int   lat_l;
    int   bc_l;
    int   cnt_l;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; start = 1'b0; A = 32'd0; B = 32'd0; borrow_in = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_D", D, 32'd0);
        check("rst_borrow", {31'd0, borrow_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 5 - 3.
        run_op("sub5_3", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0);
        @(negedge clk);
        check("sub5_3_done_pulse", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("sub5_3_D_hold", D, 32'h0000_0002);

        // 10 - 4 with a start pulse at cycle 3 while busy (ignored).
        A = 32'd10; B = 32'd4; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 32'd1; B = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(seen_l, lat_l, bc_l);
        check("ign_done_seen", {31'd0, seen_l}, 32'd1);
        check("ign_latency_rest", 32'(lat_l), 32'd7);
        check("ign_D", D, 32'd6);
        check("ign_borrow", {31'd0, borrow_out}, 32'd0);
        count_done(12, cnt_l);
        check("ign_single_done", 32'(cnt_l), 32'd0);
        check("ign_idle_busy", {31'd0, busy}, 32'd0);

        // 3 - 5 wraps with borrow.
        run_op("sub3_5", 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b1);
        @(negedge clk);

        // Reset in the middle of an operation.
        A = 32'h1234_5678; B = 32'd1; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_D", D, 32'd0);
        check("mid_rst_borrow", {31'd0, borrow_out}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_done(12, cnt_l);
        check("mid_rst_no_done", 32'(cnt_l), 32'd0);
        check("mid_rst_idle_busy", {31'd0, busy}, 32'd0);
        run_op("sub9_9", 32'd9, 32'd9, 1'b0, 32'd0, 1'b0);
        @(negedge clk);

        // 0 - 0 - 1, then back-to-back start issued in the done cycle.
        run_op("sub0_0_b1", 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        run_op("b2b_ff_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
        @(negedge clk);

        // Mixed-nibble borrow propagation.
        run_op("mix", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h0246_8ACF, 1'b0);
        @(negedge clk);

`ifdef SUB_FLAGS_EN
        run_op("flag_ovf", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0);
        check("flag_ovf_overflow", {31'd0, overflow}, 32'd1);
        check("flag_ovf_zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        run_op("flag_zero", 32'd7, 32'd7, 1'b0, 32'd0, 1'b0);
        check("flag_zero_zero", {31'd0, zero}, 32'd1);
        check("flag_zero_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
